// File: rtl/fake_fpga_io_ctrl_if.sv
// Bus bundle between design logic and the fake_fpga I/O controller.
// The master side drives requests and raw buttons. The slave side is the controller.
interface fake_fpga_io_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [7:0]           leds;
  logic [7:0]           buttons;
  logic [7:0]           btn_state;
  logic [7:0]           btn_rise;
  logic [7:0]           btn_fall;

  modport master (
    output req, req_data, buttons,
    input  gnt, leds, btn_state, btn_rise, btn_fall
  );

  modport slave (
    input  req, req_data, buttons,
    output gnt, leds, btn_state, btn_rise, btn_fall
  );
endinterface

// File: rtl/fake_fpga_io_ctrl.sv
// Round-robin LED-bank arbiter with a minimum hold window.
// Also contains a synchronizer and debouncer with edge pulses for the board buttons.
module fake_fpga_io_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int DEBOUNCE    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fake_fpga_io_ctrl_if.slave   bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         leds_q, leds_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               rr_found, pre_found;
  logic [IDX_W-1:0]   rr_idx, pre_idx;

  // Scan from farthest to nearest so the nearest set bit after last_q wins.
  // A hit at distance NUM_REQ is last_q itself. Preemption never considers that hit.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = last_q;
    pre_found = 1'b0;
    pre_idx   = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[(int'(last_q) + k) % NUM_REQ]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(last_q) + k) % NUM_REQ);
        if (k != NUM_REQ) begin
          pre_found = 1'b1;
          pre_idx   = IDX_W'((int'(last_q) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    leds_d  = leds_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          gnt_d   = NUM_REQ'(1) << rr_idx;
          leds_d  = bus.req_data[8*rr_idx +: 8];
          last_d  = rr_idx;
          hold_d  = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        // last_q always names the current owner while in OWN.
        if (!bus.req[last_q]) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (hold_q == HOLD_MAX && pre_found) begin
          gnt_d  = NUM_REQ'(1) << pre_idx;
          leds_d = bus.req_data[8*pre_idx +: 8];
          last_d = pre_idx;
          hold_d = '0;
        end else begin
          leds_d = bus.req_data[8*last_q +: 8];
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      leds_q  <= 8'h00;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      leds_q  <= leds_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.leds = leds_q;

  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= bus.buttons;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_btn
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            st_q, st_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_comb begin
      cnt_d  = '0;
      st_d   = st_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q[gi] != st_q) begin
        if (cnt_q == DB_LAST) begin
          st_d   = ~st_q;
          rise_d = ~st_q;
          fall_d = st_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        st_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        st_q   <= st_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign bus.btn_state[gi] = st_q;
    assign bus.btn_rise[gi]  = rise_q;
    assign bus.btn_fall[gi]  = fall_q;
  end
endmodule

// File: tb/tb_fake_fpga_io_ctrl.sv
// Randomized and directed bench for fake_fpga_io_ctrl.
// Checks the DUT against a cycle-level model built from ownership and debounce rules.
module tb_fake_fpga_io_ctrl;
  localparam int NR   = 4;
  localparam int HOLD = 16;
  localparam int DB   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fake_fpga_io_ctrl_if #(.NUM_REQ(NR)) bus ();

  fake_fpga_io_ctrl #(.NUM_REQ(NR), .HOLD_CYCLES(HOLD), .DEBOUNCE(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  // Model state: the owner index (-1 when nobody owns the bank).
  // m_held counts how many cycles the current owner has held the grant.
  int         m_owner, m_last, m_held;
  logic [7:0] m_leds;
  logic [7:0] m_s1, m_s2, m_state, m_rise, m_fall;
  int         m_run [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_held  = 0;
    m_leds  = 8'h00;
    m_s1 = 0; m_s2 = 0; m_state = 0; m_rise = 0; m_fall = 0;
    for (int b = 0; b < 8; b++) m_run[b] = 0;
  endtask

  function automatic int rr_pick(int base, logic [NR-1:0] r, bit excl);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (base + k) % NR;
      if (excl && c == base) continue;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [NR-1:0]   r;
    logic [8*NR-1:0] d;
    int              w;
    r = bus.req;
    d = bus.req_data;
    if (m_owner < 0) begin
      w = rr_pick(m_last, r, 1'b0);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1; m_leds = d[8*w +: 8];
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else begin
      w = (m_held >= HOLD) ? rr_pick(m_owner, r, 1'b1) : -1;
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1; m_leds = d[8*w +: 8];
      end else begin
        m_leds = d[8*m_owner +: 8];
        m_held++;
      end
    end
    m_rise = 0;
    m_fall = 0;
    for (int b = 0; b < 8; b++) begin
      if (m_s2[b] != m_state[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_run[b] = 0;
          m_state[b] = ~m_state[b];
          if (m_state[b]) m_rise[b] = 1'b1;
          else            m_fall[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.buttons;
  endtask

  task automatic compare_all(input string ph);
    logic [NR-1:0] eg;
    eg = (m_owner < 0) ? '0 : NR'(1) << m_owner;
    chk({ph, "_gnt"}, 32'(bus.gnt), 32'(eg));
    chk({ph, "_leds"}, 32'(bus.leds), 32'(m_leds));
    chk({ph, "_btn_state"}, 32'(bus.btn_state), 32'(m_state));
    chk({ph, "_btn_rise"}, 32'(bus.btn_rise), 32'(m_rise));
    chk({ph, "_btn_fall"}, 32'(bus.btn_fall), 32'(m_fall));
    chk({ph, "_gnt_onehot0"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int         rise_edge;
  logic [7:0] gap_leds;

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.buttons = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("rst0");
    rst_n = 1'b1;

    // Reset and single request
    bus.req = 4'b0100;
    bus.req_data = 32'h00A5_0000;
    step("t1");
    chk("t1_gnt_fixed", 32'(bus.gnt), 32'h4);
    chk("t1_leds_fixed", 32'(bus.leds), 32'hA5);
    $display("single request: gnt=%b leds=%h", bus.gnt, bus.leds);

    // Round-robin fairness
    do_reset();
    bus.req = '1;
    for (int c = 1; c <= 100; c++) begin
      bus.req_data = $urandom;
      step("rr");
      chk("rr_not_zero", 32'(bus.gnt != 0), 32'd1);
      if (c == 1)  chk("rr_first", 32'(bus.gnt), 32'h1);
      if (c == 17) chk("rr_second", 32'(bus.gnt), 32'h2);
      if (c == 33) chk("rr_third", 32'(bus.gnt), 32'h4);
    end
    $display("round robin: 100 cycles done, gnt=%b", bus.gnt);

    // Release and regrant
    do_reset();
    bus.req = 4'b0010;
    bus.req_data = 32'h5500_3C00;
    step("rel");
    bus.req = 4'b1010;
    repeat (4) step("rel");
    chk("rel_owner1", 32'(bus.gnt), 32'h2);
    gap_leds = bus.leds;
    bus.req = 4'b1000;
    step("rel");
    chk("rel_gap_gnt", 32'(bus.gnt), 32'h0);
    chk("rel_gap_leds", 32'(bus.leds), 32'h3C);
    chk("rel_gap_hold", 32'(bus.leds), 32'(gap_leds));
    step("rel");
    chk("rel_regrant", 32'(bus.gnt), 32'h8);
    chk("rel_regrant_leds", 32'(bus.leds), 32'h55);
    $display("release/regrant: gnt=%b leds=%h", bus.gnt, bus.leds);

    // Sole owner stays
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      bus.req_data = $urandom;
      step("sole");
      chk("sole_gnt", 32'(bus.gnt), 32'h4);
    end
    $display("sole owner: 50 cycles, gnt=%b", bus.gnt);

    // Debounce: short glitch, then a stable rise and fall
    bus.req = '0;
    bus.buttons[3] = 1'b1;
    repeat (5) step("dbg");
    bus.buttons[3] = 1'b0;
    repeat (12) step("dbg");
    chk("db_glitch_state", 32'(bus.btn_state[3]), 32'd0);
    bus.buttons[3] = 1'b1;
    rise_edge = -1;
    for (int n = 0; n < 20; n++) begin
      step("dbr");
      if (bus.btn_rise[3] && rise_edge < 0) rise_edge = n;
    end
    chk("db_rise_edge", 32'(rise_edge), 32'(DB + 1));
    chk("db_state_hi", 32'(bus.btn_state[3]), 32'd1);
    bus.buttons[3] = 1'b0;
    rise_edge = -1;
    for (int n = 0; n < 20; n++) begin
      step("dbf");
      if (bus.btn_fall[3] && rise_edge < 0) rise_edge = n;
    end
    chk("db_fall_edge", 32'(rise_edge), 32'(DB + 1));
    chk("db_state_lo", 32'(bus.btn_state[3]), 32'd0);
    $display("debounce: rise/fall latency checked on button 3");

    // Async reset mid-grant
    do_reset();
    bus.req = 4'b0001;
    bus.req_data = 32'h0000_00FF;
    repeat (3) step("ar");
    chk("ar_leds_ff", 32'(bus.leds), 32'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt_async", 32'(bus.gnt), 32'h0);
    chk("ar_leds_async", 32'(bus.leds), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1110;
    step("ar");
    chk("ar_first_lowest", 32'(bus.gnt), 32'h2);
    $display("async reset: gnt and leds cleared, regrant gnt=%b", bus.gnt);

    // Random traffic on requests and buttons
    for (int c = 0; c < 3000; c++) begin
      bus.req_data = $urandom;
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 19) == 0) bus.req[i] = ~bus.req[i];
      if ($urandom_range(0, 9) == 0) bus.buttons[$urandom_range(0, 7)] ^= 1'b1;
      step("rnd");
    end
    $display("random: 3000 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/fake_fpga_io_ctrl.md
# fake_fpga_io_ctrl

Controller between design logic and the `fake_fpga` virtual I/O board. It shares the board's single 8-bit LED bank among `NUM_REQ` requesters with a round-robin arbiter and a minimum-ownership hold window. It also synchronizes and debounces the board's 8 buttons and reports clean per-bit edge pulses.

## Interface
- `NUM_REQ`, default 4: number of LED requesters, range 2..8.
- `HOLD_CYCLES`, default 16: minimum ownership cycles before another requester may preempt; must be ≥1.
- `DEBOUNCE`, default 8: consecutive mismatch cycles before a button state change is accepted; must be ≥1.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester LED ownership request, level.
- `req_data`  in  8*NUM_REQ  LED pattern per requester; requester i uses bits [8i+7:8i].
- `gnt`  out  NUM_REQ  one-hot grant, registered.
- `leds`  out  8  registered LED bank, wired to `fake_fpga` `leds`.
- `buttons`  in  8  raw, asynchronous buttons from `fake_fpga`.
- `btn_state`  out  8  debounced button levels.
- `btn_rise`  out  8  one-cycle pulse when a `btn_state` bit goes 0→1.
- `btn_fall`  out  8  one-cycle pulse when a `btn_state` bit goes 1→0.

## Operation
- Reset values: `gnt`=0, `leds`=8'h00, `btn_state`=0, `btn_rise`=0, `btn_fall`=0, sync flops 0, debounce counters 0, hold counter 0, `last_owner`=NUM_REQ-1 (req 0 has first priority), FSM=IDLE.
- Arbiter FSM, states IDLE and OWN:
  - IDLE: if any `req` bit is set, select the first set bit scanning `last_owner+1`, `last_owner+2`, … (mod NUM_REQ). Set `gnt` one-hot, load `leds` with the winner's `req_data`, set `last_owner` to the winner, clear the hold counter, and go to OWN. If no request, `leds` holds its value.
  - OWN, owner `req` high: load `leds` from the owner's `req_data` every cycle. The hold counter increments and saturates at HOLD_CYCLES-1.
  - OWN, owner `req` low: clear `gnt` and go to IDLE. `leds` keeps the last owner value. There is no same-edge regrant; the next arbitration happens in IDLE.
  - OWN, counter = HOLD_CYCLES-1 and another `req` set: preempt on that edge. Pick the next requester round-robin from the current owner (excluding the owner), switch `gnt` directly, load its data, and clear the counter. Stay in OWN.
  - OWN, counter saturated and no other requester: the owner keeps the grant indefinitely.
- `gnt` is always zero or one-hot. It never has multiple bits set.
- Debounce, per bit:
  - Two-flop synchronizer gives `sync`.
  - If `sync` ≠ `btn_state`, the counter increments.
  - If they are equal, the counter clears.
  - On the edge where the counter would reach DEBOUNCE, `btn_state` flips, the counter clears, and the matching `btn_rise`/`btn_fall` bit pulses for exactly one cycle.
  - Counter width is clog2(DEBOUNCE+1).
- Debounce is independent of arbitration.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k gives `gnt` and `leds` valid after edge k.
- Data tracking: `leds` equals the owner's `req_data` sampled at the previous edge (1-cycle latency).
- Release: owner `req` low at edge k clears `gnt` after edge k. The earliest next grant is after edge k+1.
- Preemption: the new owner gets the grant on the edge where the old owner has held for HOLD_CYCLES cycles. The old owner has `gnt` for exactly HOLD_CYCLES cycles, with no idle cycle between owners.
- Button latency: raw change stable before edge 0 → `sync` valid after edge 1 → `btn_state` and the edge pulse change after edge DEBOUNCE+1.
- A glitch shorter than DEBOUNCE synced cycles produces no change.
- `rst_n` low mid-operation immediately forces all reset values, including dropping `gnt` and clearing `leds`. Arbitration after release restarts from req 0 priority.

## Test plan
- Reset and single request: assert `rst_n` low then release, `req`=4'b0100, `req_data[23:16]`=8'hA5. Expect `gnt`=4'b0100 and `leds`=8'hA5 one edge after `req` is sampled; all outputs 0 before that.
- Round-robin fairness: all `req` high for 100 cycles with HOLD_CYCLES=16. Expect grant order 0,1,2,3,0,…, each owner holding exactly 16 cycles, `gnt` never zero and never multi-hot.
- Release and regrant: owner 1 drops `req` at cycle 5 while req 3 is pending. Expect `gnt`=0 for one cycle, then `gnt`=4'b1000, with `leds` holding owner 1's last value during the gap.
- Sole owner stays: req 2 only, held for 50 cycles. Expect `gnt`=4'b0100 throughout and `leds` tracking `req_data` changes with 1-cycle latency.
- Debounce: `buttons[3]` pulses high for 5 cycles (no change expected), then holds high for 20 cycles. Expect `btn_state[3]`=1 and `btn_rise[3]` pulsing for one cycle exactly DEBOUNCE+1 edges after the stable rise. Dropping the button low gives one `btn_fall[3]` pulse.
- Async reset mid-grant: `rst_n` low during OWN with `leds`=8'hFF. Expect `gnt`=0 and `leds`=0 immediately without waiting for an edge; after release the first grant goes to the lowest set `req` index.
